// File: rtl/mux_sweep_pkg.sv
// Shared types and the reference select function for the mux sweep checker.
// The function is also used by the bench to model the mux under test.
package mux_sweep_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETTLE = 2'd1,
      ST_SAMPLE = 2'd2,
      ST_DONE   = 2'd3
   } state_t;

   localparam int MAX_W = 4;

   // Operands are zero-extended to MAX_W so one function serves every width.
   function automatic logic [MAX_W-1:0] mux_exp(input logic [MAX_W-1:0] a,
                                                input logic [MAX_W-1:0] b,
                                                input logic             c);
      return c ? b : a;
   endfunction

endpackage

// File: rtl/mux_sweep_checker_settle_timer.sv
// Loadable down-counter that paces how long each vector is held.
// zero is high once the count reaches 0.
module settle_timer #(
   parameter int SETTLE = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic load,
   input  logic dec,
   output logic zero
);

   localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

   logic [CW-1:0] cnt;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= CW'(SETTLE - 1);
      end else if (dec) begin
         cnt <= cnt - CW'(1);
      end
   end

   assign zero = (cnt == '0);

endmodule

// File: rtl/mux_sweep_checker.sv
// Exhaustive sweep engine for a 2:1 select mux: drives {a,b,c} in index
// order, holds each vector SETTLE+1 cycles and counts mismatches on z.
module mux_sweep_checker
   import mux_sweep_pkg::*;
#(
   parameter int W      = 1,
   parameter int SETTLE = 4
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            start,
   output logic [W-1:0]    a,
   output logic [W-1:0]    b,
   output logic            c,
   input  logic [W-1:0]    z,
   output logic            busy,
   output logic            done,
   output logic            pass,
   output logic [2*W+1:0]  err_count,
   output logic [2*W:0]    first_fail,
   output logic            fail_seen
);

   localparam int              IW   = 2 * W + 1;
   localparam logic [IW-1:0]   LAST = '1;

   state_t          state;
   logic [IW-1:0]   vec;
   logic            load;
   logic            dec;
   logic            zero;
   logic [MAX_W-1:0] exp_full;
   logic            mismatch;

   // The vector register is the sweep index itself: c is the LSB, a the MSB.
   assign {a, b, c} = vec;

   always_comb begin
      exp_full = mux_exp(MAX_W'(a), MAX_W'(b), c);
      mismatch = (MAX_W'(z) != exp_full);
      load     = (((state == ST_IDLE) || (state == ST_DONE)) && start) ||
                 ((state == ST_SAMPLE) && (vec != LAST));
      dec      = (state == ST_SETTLE) && !zero;
   end

   settle_timer #(
      .SETTLE (SETTLE)
   ) u_timer (
      .clk   (clk),
      .reset (reset),
      .load  (load),
      .dec   (dec),
      .zero  (zero)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= ST_IDLE;
         vec        <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
         pass       <= 1'b0;
         err_count  <= '0;
         first_fail <= '0;
         fail_seen  <= 1'b0;
      end else begin
         case (state)
            ST_IDLE, ST_DONE: begin
               if (start) begin
                  state      <= ST_SETTLE;
                  vec        <= '0;
                  busy       <= 1'b1;
                  done       <= 1'b0;
                  pass       <= 1'b0;
                  err_count  <= '0;
                  first_fail <= '0;
                  fail_seen  <= 1'b0;
               end
            end
            ST_SETTLE: begin
               if (zero) begin
                  state <= ST_SAMPLE;
               end
            end
            ST_SAMPLE: begin
               if (mismatch) begin
                  err_count <= err_count + (IW+1)'(1);
                  if (!fail_seen) begin
                     first_fail <= vec;
                     fail_seen  <= 1'b1;
                  end
               end
               // Final vector stays on a/b/c while results are held in DONE.
               if (vec == LAST) begin
                  state <= ST_DONE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  pass  <= (err_count == '0) && !mismatch;
               end else begin
                  vec   <= vec + IW'(1);
                  state <= ST_SETTLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mux_sweep_checker.sv
// Directed bench for mux_sweep_checker: a W=1/SETTLE=4 and a W=2/SETTLE=1
// instance, each attached to a mux model with selectable faults.
module tb_mux_sweep_checker;
   import mux_sweep_pkg::*;

   logic clk = 1'b0;
   logic reset = 1'b0;
   logic start1 = 1'b0;
   logic start2 = 1'b0;
   int   mode = 0;   // 0 correct, 1 z stuck 0, 2 swapped select, 3 z[1] stuck 1

   logic [0:0] a1, b1, z1;
   logic       c1, busy1, done1, pass1, fs1;
   logic [3:0] err1;
   logic [2:0] ff1;

   logic [1:0] a2, b2, z2;
   logic       c2, busy2, done2, pass2, fs2;
   logic [5:0] err2;
   logic [4:0] ff2;

   int nvec = 0;
   int nfail = 0;

   always #5 clk = ~clk;

   mux_sweep_checker #(.W(1), .SETTLE(4)) dut1 (
      .clk(clk), .reset(reset), .start(start1), .a(a1), .b(b1), .c(c1), .z(z1),
      .busy(busy1), .done(done1), .pass(pass1), .err_count(err1),
      .first_fail(ff1), .fail_seen(fs1)
   );

   mux_sweep_checker #(.W(2), .SETTLE(1)) dut2 (
      .clk(clk), .reset(reset), .start(start2), .a(a2), .b(b2), .c(c2), .z(z2),
      .busy(busy2), .done(done2), .pass(pass2), .err_count(err2),
      .first_fail(ff2), .fail_seen(fs2)
   );

   always_comb begin
      z1 = 1'(mux_exp(4'(a1), 4'(b1), c1));
      if (mode == 1) z1 = 1'b0;
      if (mode == 2) z1 = c1 ? a1 : b1;
      z2 = 2'(mux_exp(4'(a2), 4'(b2), c2));
      if (mode == 3) z2 = z2 | 2'b10;
   end

   // Selected-instance views, zero-extended to common widths.
   int   sel = 0;
   logic s_busy, s_done, s_pass, s_fs;
   int   s_err, s_ff, s_vec;
   always_comb begin
      s_busy = sel ? busy2 : busy1;
      s_done = sel ? done2 : done1;
      s_pass = sel ? pass2 : pass1;
      s_fs   = sel ? fs2   : fs1;
      s_err  = sel ? int'(err2) : int'(err1);
      s_ff   = sel ? int'(ff2)  : int'(ff1);
      s_vec  = sel ? int'({a2, b2, c2}) : int'({a1, b1, c1});
   end

   task automatic check(input string name, input int act, input int req);
      nvec++;
      if (act !== req) begin
         nfail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, req);
      end
   endtask

   task automatic set_start(input logic v);
      if (sel) start2 = v; else start1 = v;
   endtask

   typedef struct {
      int inst;
      int fmode;
      int pulse;
      int exp_err;
      int exp_ff;
      int exp_fs;
      int exp_pass;
   } vec_t;

   // Starts a sweep on the selected instance (a restart if it sits in DONE)
   // and follows it to done, checking the vector walk and the results.
   task automatic run_sweep(input vec_t v);
      int hold, n, k, bad_walk, bad_flag;
      sel  = v.inst;
      mode = v.fmode;
      hold = v.inst ? 2 : 5;
      n    = v.inst ? 32 : 8;
      set_start(1'b1);
      @(posedge clk); #1;
      set_start(1'b0);
      check("post_start_busy", int'(s_busy), 1);
      check("post_start_done", int'(s_done), 0);
      check("post_start_err",  s_err, 0);
      check("post_start_fs",   int'(s_fs), 0);
      check("post_start_vec",  s_vec, 0);
      k = 0; bad_walk = 0; bad_flag = 0;
      while (!s_done && k < 200) begin
         @(posedge clk); #1;
         k++;
         set_start((v.pulse != 0) && (k == 3 || k == 20));
         if (s_vec != ((k / hold < n) ? k / hold : n - 1)) bad_walk++;
         if (!s_done && !s_busy) bad_flag++;
         if (s_done && s_busy) bad_flag++;
      end
      set_start(1'b0);
      check("done_edge",  k, n * hold);
      check("vec_walk",   bad_walk, 0);
      check("busy_done",  bad_flag, 0);
      check("err_count",  s_err, v.exp_err);
      check("fail_seen",  int'(s_fs), v.exp_fs);
      if (v.exp_fs != 0) check("first_fail", s_ff, v.exp_ff);
      check("pass",       int'(s_pass), v.exp_pass);
      check("last_vec",   s_vec, n - 1);
   endtask

   vec_t tbl[7];

   initial begin
      tbl[0] = '{0, 0, 0, 0,  0, 0, 1};
      tbl[1] = '{0, 1, 0, 4,  3, 1, 0};
      tbl[2] = '{0, 1, 0, 4,  3, 1, 0};
      tbl[3] = '{0, 2, 0, 4,  2, 1, 0};
      tbl[4] = '{0, 0, 1, 0,  0, 0, 1};
      tbl[5] = '{1, 0, 0, 0,  0, 0, 1};
      tbl[6] = '{1, 3, 0, 16, 0, 1, 0};

      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      @(posedge clk); #1;
      check("rst_busy", int'(busy1), 0);
      check("rst_done", int'(done1), 0);
      check("rst_pass", int'(pass1), 0);
      check("rst_err",  int'(err1), 0);
      check("rst_vec",  int'({a1, b1, c1}), 0);
      check("rst_done2", int'(done2), 0);

      for (int i = 0; i < 7; i++) begin
         run_sweep(tbl[i]);
      end

      // Reset mid-sweep with a failure already recorded.
      sel = 0; mode = 2;
      start1 = 1'b1;
      @(posedge clk); #1;
      start1 = 1'b0;
      repeat (17) @(posedge clk);
      #1;
      check("pre_rst_err", int'(err1), 1);
      reset = 1'b1;
      #1;
      check("mid_rst_vec",  int'({a1, b1, c1}), 0);
      check("mid_rst_busy", int'(busy1), 0);
      check("mid_rst_done", int'(done1), 0);
      check("mid_rst_pass", int'(pass1), 0);
      check("mid_rst_err",  int'(err1), 0);
      check("mid_rst_ff",   int'(ff1), 0);
      check("mid_rst_fs",   int'(fs1), 0);
      @(posedge clk); #1;
      reset = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("idle_after_rst", int'(busy1), 0);
      run_sweep(tbl[0]);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
      $finish;
   end

endmodule

// File: doc/mux_sweep_checker.md
# mux_sweep_checker

Self-checking sweep engine for the 1-bit/W-bit 2:1 select mux, `yMux1` and its wider variants. It generates every `{a,b,c}` input combination in nested-loop order, holds each vector for a fixed settle time, samples the mux output and compares it against the reference select function. It also accumulates an error count. It sits on both sides of the mux under test: it drives the mux inputs and consumes its output, replacing hand-written exhaustive stimulus loops with a synthesizable, cycle-exact checker.

## Interface
Parameters:
- `W`, default 1: width of data inputs `a` and `b`. Legal range 1..4.
- `SETTLE`, default 4: cycles each vector is held before sampling. Legal range 1..255.

Derived: `N = 2^(2W+1)` vectors. `IW = 2W+1` index bits.

Ports:
- `clk`, input, 1 bit: single clock. All state updates on the rising edge.
- `reset`, input, 1 bit: asynchronous, active-high reset.
- `start`, input, 1 bit: begin sweep. Sampled only in IDLE or DONE.
- `a`, output, W bits: mux data input 0. Registered.
- `b`, output, W bits: mux data input 1. Registered.
- `c`, output, 1 bit: mux select. Registered.
- `z`, input, W bits: mux output under test.
- `busy`, output, 1 bit: high in SETTLE and SAMPLE.
- `done`, output, 1 bit: high in DONE. Level signal.
- `pass`, output, 1 bit: `done && err_count==0`.
- `err_count`, output, IW+1 bits: number of mismatching vectors in the current or last sweep.
- `first_fail`, output, IW bits: index of the first mismatching vector. Valid when `fail_seen`=1.
- `fail_seen`, output, 1 bit: at least one mismatch this sweep.

## Operation
- Vector index `idx` maps as `{a,b,c} = idx`, with `c` as the LSB, `b` in the middle and `a` as the MSB. Index 0..N-1 ascending means `a` is the outer loop and `c` the inner loop.
- Expected value: `exp = c ? b : a`. A vector mismatches if `z != exp` on any bit.
- States:
  - IDLE: outputs at reset values.
    - `start` → SETTLE. Load `idx=0`, drive vector 0, set `wcnt=SETTLE-1`, clear `err_count`, `fail_seen` and `first_fail`.
  - SETTLE: hold the vector.
    - `wcnt==0` → SAMPLE.
    - Otherwise decrement `wcnt`.
  - SAMPLE: compare `z` against `exp` at the exit edge.
    - On mismatch, `err_count++`. If `fail_seen==0`, set `first_fail=idx` and `fail_seen=1`.
    - If `idx==N-1` → DONE, with `a`/`b`/`c` holding the last vector.
    - Otherwise `idx++`, drive the next vector, reload `wcnt=SETTLE-1` → SETTLE.
  - DONE: results held stable.
    - `start` → SETTLE with the same clearing as from IDLE. This is a restart.
- `start` in SETTLE or SAMPLE is ignored. No abort; only `reset` terminates a sweep.
- Arithmetic:
  - `err_count` maximum is N, which fits IW+1 bits. It never wraps.
  - `idx` never wraps; the terminal compare is on N-1.

## Timing
- Reset (asynchronous, immediate) sets:
  - state=IDLE
  - `a`=0, `b`=0, `c`=0
  - `busy`=0, `done`=0, `pass`=0
  - `err_count`=0, `first_fail`=0, `fail_seen`=0
- Reset mid-sweep discards all partial results. A new `start` is needed after `reset` deasserts.
- Let E0 be the edge that samples `start`=1. Vector 0 appears after E0.
- Each vector is held exactly SETTLE+1 cycles: SETTLE cycles in SETTLE plus 1 in SAMPLE.
- Vector k is compared at edge E((k+1)(SETTLE+1)). `z` must be stable in the cycle before that edge.
- `done` rises after edge E(N(SETTLE+1)). For W=1, SETTLE=4, that is E40.
- `busy` is high from after E0 until the `done` rise. `busy` and `done` are never both high.
- `err_count`/`first_fail` update on SAMPLE exit edges only and are stable otherwise.
- Back-to-back restart: `start` high in the first DONE cycle gives DONE for exactly 1 cycle, then vector 0.

## Structure
- Shared package `mux_sweep_pkg`:
  - state enum (IDLE, SETTLE, SAMPLE, DONE)
  - pure function `mux_exp(a,b,c)` returning `c ? b : a`, reused by the bench scoreboard
- One sub-module, `settle_timer`: loadable down-counter with a `zero` flag, sized by `$clog2(SETTLE)`.
- FSM, vector register and result registers live in `mux_sweep_checker`.

## Test plan
- W=1, SETTLE=4, correct `yMux1` attached, pulse `start` → `done` after E40, `err_count`=0, `pass`=1, `fail_seen`=0. `a`/`b`/`c` visit 000…111 in order, each held 5 cycles.
- `z` stuck at 0 → `err_count`=4 (idx 3,4,6,7), `first_fail`=3, `pass`=0.
- Swapped mux (selects `a` when `c`=1) → `err_count`=4 (idx 2,3,4,5), `first_fail`=2.
- Assert `reset` at cycle 17 mid-sweep → all outputs return to reset values immediately. The next `start` gives a full clean sweep with `err_count`=0.
- `start` pulsed at cycles 3 and 20 during the sweep → ignored, `done` still after E40. `start` in DONE → results cleared and sweep reruns identically.
- W=2, SETTLE=1, correct mux → 32 vectors, `done` after E64, `pass`=1. With `z[1]` stuck at 1, `err_count`=16 and `first_fail`=0.
